// File: rtl/ps2_key_serializer.sv
// Turns key events into PS/2 device-to-host frames (start, 8 data LSB first, odd parity, stop),
// buffered through a 16-byte FIFO and held off while the host inhibits the clock line.
module ps2_key_serializer #(
  parameter int HALF_BIT   = 1432,
  parameter int GAP_HALVES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        ps2_clk_in,
  output logic        ps2_clk_out,
  output logic        ps2_data_out,
  output logic        busy,
  output logic        overflow
);

  localparam int GAP_CYCLES = GAP_HALVES * HALF_BIT;
  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] half_cnt;
  logic [3:0]    bit_cnt;
  logic          sync1, sync2;
  logic          toggle_q, armed;
  logic [7:0]    mem [16];
  logic [3:0]    wr_ptr, rd_ptr;
  logic [4:0]    count;

  logic          event_fire;
  logic [1:0]    ev_n;
  logic [7:0]    ev0, ev1, ev2;
  logic [4:0]    free_slots;
  logic          fits;
  logic          pop;
  logic [7:0]    head;
  logic [10:0]   frame;
  logic [3:0]    next_bit;

  always_comb begin
    event_fire = armed && (ps2_key[10] != toggle_q);
    ev0  = ps2_key[7:0];
    ev1  = ps2_key[7:0];
    ev2  = ps2_key[7:0];
    ev_n = 2'd1;
    case ({ps2_key[8], ps2_key[9]})
      2'b10: begin ev0 = 8'hE0; ev1 = 8'hF0; ev_n = 2'd3; end
      2'b11: begin ev0 = 8'hE0; ev_n = 2'd2; end
      2'b00: begin ev0 = 8'hF0; ev_n = 2'd2; end
      default: ;
    endcase
    // The byte in flight keeps its slot until its stop bit ends; a same-cycle pop frees it first.
    pop        = (state == LOW) && (half_cnt == HALF_LAST) && (bit_cnt == 4'd10);
    free_slots = 5'd16 - count + {4'd0, pop};
    fits       = ({3'd0, ev_n} <= free_slots);
    head       = mem[rd_ptr];
    frame      = {1'b1, ~^head, head, 1'b0};
    next_bit   = bit_cnt + 4'd1;
  end

  assign busy = (count != 5'd0) || (state != IDLE);

  // The first clock after reset only samples the toggle so a stale level is not an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
      armed    <= 1'b0;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
    end else begin
      toggle_q <= ps2_key[10];
      armed    <= 1'b1;
      sync1    <= ps2_clk_in;
      sync2    <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 4'd1;
      if (event_fire && fits) begin
        wr_ptr <= wr_ptr + {2'd0, ev_n};
        count  <= count + {3'd0, ev_n} - {4'd0, pop};
      end else begin
        count <= count - {4'd0, pop};
        if (event_fire) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (event_fire && fits) begin
      mem[wr_ptr] <= ev0;
      if (ev_n >= 2'd2) mem[wr_ptr + 4'd1] <= ev1;
      if (ev_n == 2'd3) mem[wr_ptr + 4'd2] <= ev2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      half_cnt     <= '0;
      bit_cnt      <= 4'd0;
      ps2_clk_out  <= 1'b1;
      ps2_data_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if ((count != 5'd0) && sync2) begin
            state        <= HIGH;
            half_cnt     <= '0;
            bit_cnt      <= 4'd0;
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= frame[0];
          end
        end
        HIGH: begin
          // Host inhibit aborts the frame unless the stop bit is already on the line.
          if (!sync2 && (bit_cnt < 4'd10)) begin
            state        <= WAIT;
            half_cnt     <= '0;
            bit_cnt      <= 4'd0;
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= 1'b1;
          end else if (half_cnt == HALF_LAST) begin
            state       <= LOW;
            half_cnt    <= '0;
            ps2_clk_out <= 1'b0;
          end else begin
            half_cnt <= half_cnt + CW'(1);
          end
        end
        LOW: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt    <= '0;
            ps2_clk_out <= 1'b1;
            if (bit_cnt == 4'd10) begin
              state        <= GAP;
              bit_cnt      <= 4'd0;
              ps2_data_out <= 1'b1;
            end else begin
              state        <= HIGH;
              bit_cnt      <= next_bit;
              ps2_data_out <= frame[next_bit];
            end
          end else begin
            half_cnt <= half_cnt + CW'(1);
          end
        end
        GAP: begin
          if (half_cnt == GAP_LAST) begin
            state    <= IDLE;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + CW'(1);
          end
        end
        WAIT: begin
          if (sync2) begin
            state    <= GAP;
            half_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Directed bench for ps2_key_serializer: a line monitor decodes frames while a vector table
// and hand-written sequences cover overflow, inhibit, mid-frame reset and pre-event inhibit.
module tb_ps2_key_serializer;

  localparam int HB = 4;
  localparam int GH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        ps2_clk_in;
  logic        ps2_clk_out, ps2_data_out, busy, overflow;

  ps2_key_serializer #(.HALF_BIT(HB), .GAP_HALVES(GH)) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .ps2_clk_in(ps2_clk_in),
    .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // Host-side receiver: samples data on each falling clock edge, drops partial frames after a long high.
  logic        prev_clk = 1'b1, prev_data = 1'b1;
  int          bit_idx = 0, high_run = 100, falls = 0;
  int          frame_err = 0, low_glitch = 0;
  int          frame_start = -1, last_rise = -1, busy_fall = -1;
  logic [10:0] shift = '0, last_raw = '0;
  logic [7:0]  rx[$];

  always @(negedge clk) begin
    if (prev_clk && !ps2_clk_out) begin
      falls++;
      shift[bit_idx] = ps2_data_out;
      if (bit_idx == 10) begin
        if (shift[0] != 1'b0 || shift[10] != 1'b1 || (^shift[9:1]) != 1'b1) frame_err++;
        rx.push_back(shift[8:1]);
        last_raw = shift;
        bit_idx = 0;
      end else begin
        bit_idx++;
      end
    end
    if (!prev_clk && ps2_clk_out) last_rise = cyc;
    if (prev_data && !ps2_data_out && ps2_clk_out && high_run > HB) frame_start = cyc;
    if (!prev_clk && !ps2_clk_out && (prev_data != ps2_data_out)) low_glitch++;
    high_run = ps2_clk_out ? high_run + 1 : 0;
    if (high_run > HB + 2) bit_idx = 0;
    prev_clk  = ps2_clk_out;
    prev_data = ps2_data_out;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic ext, input logic pressed, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) check_output("idle_timeout", 32'(busy), 32'd0);
    busy_fall = cyc;
  endtask

  task automatic wait_frame_after(input int ref_cyc, input int budget, output int dly);
    int n = 0;
    while (frame_start <= ref_cyc && n < budget) begin tick(); n++; end
    if (frame_start <= ref_cyc) check_output("frame_start_timeout", 32'd0, 32'd1);
    dly = frame_start - ref_cyc;
  endtask

  typedef struct {
    logic        ext;
    logic        pressed;
    logic [7:0]  code;
    int          n;
    logic [23:0] bytes;
    logic        par;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, base, r, d;
    vecs[0] = '{1'b0, 1'b1, 8'h1C, 1, 24'h00001C, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h74, 3, 24'h74F0E0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h75, 2, 24'h0075E0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h5A, 2, 24'h005AF0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 1, 24'h000000, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'hFF, 1, 24'h0000FF, 1'b1};

    reset = 1'b1; ps2_key = '0; ps2_clk_in = 1'b1;
    repeat (3) tick();
    check_output("rst_clk_out", 32'(ps2_clk_out), 32'd1);
    check_output("rst_data_out", 32'(ps2_data_out), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);

    ps2_key[10] = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check_output("first_clk_no_event_busy", 32'(busy), 32'd0);
    check_output("first_clk_no_event_clock", 32'(falls), 32'd0);

    for (int k = 0; k < 6; k++) begin
      rx.delete();
      apply_stimulus(vecs[k].ext, vecs[k].pressed, vecs[k].code);
      check_output($sformatf("v%0d_busy_rise", k), 32'(busy), 32'd1);
      wait_idle(600);
      check_output($sformatf("v%0d_count", k), 32'(rx.size()), 32'(vecs[k].n));
      for (int i = 0; i < vecs[k].n; i++)
        check_output($sformatf("v%0d_byte%0d", k, i), 32'(rx[i]), 32'(vecs[k].bytes[8*i +: 8]));
      check_output($sformatf("v%0d_raw_frame", k), 32'(last_raw), 32'({1'b1, vecs[k].par, vecs[k].code, 1'b0}));
      check_output($sformatf("v%0d_frame_len", k), 32'(last_rise - frame_start), 32'd88);
      check_output($sformatf("v%0d_busy_after_stop", k), 32'(busy_fall - last_rise), 32'd16);
    end
    check_output("no_overflow_yet", 32'(overflow), 32'd0);

    // Six 3-byte events back to back: only five fit in 16 slots.
    rx.delete();
    for (int k = 0; k < 6; k++) apply_stimulus(1'b1, 1'b0, 8'h10 + 8'(k));
    check_output("ovf_set", 32'(overflow), 32'd1);
    wait_idle(3000);
    check_output("ovf_count", 32'(rx.size()), 32'd15);
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("ovf_e%0d_b0", i), 32'(rx[3*i]), 32'hE0);
      check_output($sformatf("ovf_e%0d_b1", i), 32'(rx[3*i+1]), 32'hF0);
      check_output($sformatf("ovf_e%0d_b2", i), 32'(rx[3*i+2]), 32'h10 + 32'(i));
    end
    check_output("ovf_sticky", 32'(overflow), 32'd1);

    // Host inhibit during the high phase of bit 5 (data bit 4 of 2A is 0).
    rx.delete();
    base = falls;
    apply_stimulus(1'b0, 1'b1, 8'h2A);
    n = 0;
    while (!(falls == base + 5 && ps2_clk_out) && n < 200) begin tick(); n++; end
    check_output("inh_reach_bit5", 32'(falls - base), 32'd5);
    check_output("inh_bit5_data", 32'(ps2_data_out), 32'd0);
    ps2_clk_in = 1'b0;
    n = 0;
    while (!(ps2_clk_out && ps2_data_out) && n < 3) begin tick(); n++; end
    check_output("inh_release", 32'({ps2_clk_out, ps2_data_out}), 32'd3);
    base = falls;
    repeat (20) tick();
    check_output("inh_no_clock", 32'(falls - base), 32'd0);
    check_output("inh_busy_held", 32'(busy), 32'd1);
    ps2_clk_in = 1'b1;
    r = cyc;
    wait_frame_after(r, 60, d);
    check_range("inh_restart_delay", d, 18, 22);
    wait_idle(400);
    check_output("inh_count", 32'(rx.size()), 32'd1);
    check_output("inh_byte", 32'(rx[0]), 32'h2A);

    // Reset while bit 3 is in its low phase.
    rx.delete();
    base = falls;
    apply_stimulus(1'b0, 1'b1, 8'h33);
    n = 0;
    while (!(falls == base + 4 && !ps2_clk_out) && n < 200) begin tick(); n++; end
    check_output("mid_reach_bit3_low", 32'(falls - base), 32'd4);
    reset = 1'b1;
    #1;
    check_output("mid_rst_clk_out", 32'(ps2_clk_out), 32'd1);
    check_output("mid_rst_data_out", 32'(ps2_data_out), 32'd1);
    check_output("mid_rst_busy", 32'(busy), 32'd0);
    check_output("mid_rst_overflow", 32'(overflow), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    check_output("mid_rst_fifo_empty", 32'(busy), 32'd0);
    apply_stimulus(1'b0, 1'b1, 8'h44);
    wait_idle(400);
    check_output("mid_rst_count", 32'(rx.size()), 32'd1);
    check_output("mid_rst_byte", 32'(rx[0]), 32'h44);

    // Clock line held low by the host before the event arrives.
    ps2_clk_in = 1'b0;
    repeat (4) tick();
    rx.delete();
    base = falls;
    apply_stimulus(1'b0, 1'b1, 8'h16);
    repeat (30) tick();
    check_output("pre_inh_no_clock", 32'(falls - base), 32'd0);
    check_output("pre_inh_busy", 32'(busy), 32'd1);
    check_output("pre_inh_lines", 32'({ps2_clk_out, ps2_data_out}), 32'd3);
    ps2_clk_in = 1'b1;
    r = cyc;
    wait_frame_after(r, 20, d);
    check_range("pre_inh_start_delay", d, 2, 5);
    wait_idle(400);
    check_output("pre_inh_count", 32'(rx.size()), 32'd1);
    check_output("pre_inh_byte", 32'(rx[0]), 32'h16);

    check_output("frame_format_errors", 32'(frame_err), 32'd0);
    check_output("data_change_in_low", 32'(low_glitch), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
